// File: rtl/axil_pkg.sv
// Shared AXI4-Lite types and widths for the LSU/data-memory path.
// Also hosts the pmem access calls the data memory uses.
package axil_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int STRB_W = DATA_W / 8;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    SLVERR = 2'b10
  } axil_resp_e;

  typedef enum logic [2:0] {
    IDLE,
    RD_WAIT,
    RD_RESP,
    WR_WAIT,
    WR_RESP
  } dmem_state_e;

  // Behavioural stand-in for the C-side physical memory model.
  logic [31:0] pmem [int unsigned];
  int unsigned pmem_wr_cnt = 0;
  logic [31:0] pmem_wr_addr = '0;
  logic [7:0]  pmem_wr_mask = '0;

  function automatic logic [31:0] word_addr(input logic [31:0] a);
    return a & ~32'h3;
  endfunction

  function automatic logic [31:0] dpic_pmem_read(
    input logic [31:0] addr
  );
    int unsigned k;
    k = addr >> 2;
    return pmem.exists(k) ? pmem[k] : '0;
  endfunction

  function automatic void dpic_pmem_write(
    input logic [31:0] addr,
    input logic [31:0] data,
    input logic [7:0]  mask
  );
    logic [31:0] w;
    w = dpic_pmem_read(addr);
    for (int i = 0; i < 4; i++)
      if (mask[i]) w[8*i +: 8] = data[8*i +: 8];
    pmem[addr >> 2] = w;
    pmem_wr_cnt  = pmem_wr_cnt + 1;
    pmem_wr_addr = addr;
    pmem_wr_mask = mask;
  endfunction

endpackage

// File: rtl/axil_dmem_if.sv
// AXI4-Lite bus bundle between the LSU (master) and data memory (slave).
interface axil_dmem_if;
  import axil_pkg::*;

  logic [ADDR_W-1:0] araddr;
  logic              arvalid;
  logic              arready;
  logic [DATA_W-1:0] rdata;
  logic [1:0]        rresp;
  logic              rvalid;
  logic              rready;
  logic [ADDR_W-1:0] awaddr;
  logic              awvalid;
  logic              awready;
  logic [DATA_W-1:0] wdata;
  logic [STRB_W-1:0] wstrb;
  logic              wvalid;
  logic              wready;
  logic [1:0]        bresp;
  logic              bvalid;
  logic              bready;

  modport master (
    output araddr, arvalid, rready,
    output awaddr, awvalid, wdata, wstrb, wvalid, bready,
    input  arready, rdata, rresp, rvalid,
    input  awready, wready, bresp, bvalid
  );

  modport slave (
    input  araddr, arvalid, rready,
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready,
    output arready, rdata, rresp, rvalid,
    output awready, wready, bresp, bvalid
  );

endinterface

// File: rtl/axil_dmem_lfsr8.sv
// 8-bit Fibonacci LFSR, taps 8,6,5,4; steps only when enabled.
module lfsr8 #(
  parameter logic [7:0] SEED = 8'hA5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  output logic [7:0] state
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= SEED;
    end else if (en) begin
      state <= {state[6:0],
                state[7] ^ state[5] ^ state[4] ^ state[3]};
    end
  end

endmodule

// File: rtl/axil_dmem.sv
// AXI4-Lite data-memory slave with a per-transaction access delay.
import axil_pkg::*;

module axil_dmem #(
  parameter int unsigned MIN_LAT   = 1,
  parameter logic [3:0]  RAND_MASK = 4'hF,
  parameter logic [7:0]  LFSR_SEED = 8'hA5
) (
  input  logic       clk,
  input  logic       rst_n,
  axil_dmem_if.slave bus
);

  dmem_state_e state, state_nx;

  logic [4:0]        cnt;
  logic [4:0]        dly;
  logic [7:0]        lfsr;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] acc_addr;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] acc_wdata;
  logic [DATA_W-1:0] rdata_q;
  logic [STRB_W-1:0] wstrb_q;
  logic [STRB_W-1:0] acc_wstrb;
  logic              idle;
  logic              acc_rd;
  logic              acc_wr;
  logic              zero;
  logic              rd_fire;
  logic              wr_fire;

  assign idle   = state == IDLE;
  assign acc_rd = idle && bus.arvalid;
  assign acc_wr = idle && !bus.arvalid
               && bus.awvalid && bus.wvalid;

  assign dly  = 5'(MIN_LAT)
              + 5'(lfsr & {4'h0, RAND_MASK});
  assign zero = dly == 5'd0;

  // The acceptance cycle counts as the first delay cycle.
  assign rd_fire = (acc_rd && zero)
                || (state == RD_WAIT && cnt == 5'd0);
  assign wr_fire = (acc_wr && zero)
                || (state == WR_WAIT && cnt == 5'd0);

  assign acc_addr  = !idle  ? addr_q
                   : acc_rd ? bus.araddr
                   :          bus.awaddr;
  assign acc_wdata = idle ? bus.wdata : wdata_q;
  assign acc_wstrb = idle ? bus.wstrb : wstrb_q;

  lfsr8 #(.SEED(LFSR_SEED)) u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (acc_rd || acc_wr),
    .state (lfsr)
  );

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (acc_rd)
          state_nx = rd_fire ? RD_RESP : RD_WAIT;
        else if (acc_wr)
          state_nx = wr_fire ? WR_RESP : WR_WAIT;
      end
      RD_WAIT: if (rd_fire) state_nx = RD_RESP;
      WR_WAIT: if (wr_fire) state_nx = WR_RESP;
      RD_RESP: if (bus.rready) state_nx = IDLE;
      WR_RESP: if (bus.bready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      rdata_q <= '0;
    end else begin
      state <= state_nx;
      if (acc_rd || acc_wr) begin
        addr_q <= acc_addr;
        cnt    <= zero ? 5'd0 : dly - 5'd1;
      end else if (cnt != 5'd0) begin
        cnt <= cnt - 5'd1;
      end
      if (acc_wr) begin
        wdata_q <= bus.wdata;
        wstrb_q <= bus.wstrb;
      end
      if (rd_fire)
        rdata_q <= dpic_pmem_read(word_addr(acc_addr));
      if (wr_fire)
        dpic_pmem_write(word_addr(acc_addr), acc_wdata,
                        {4'b0, acc_wstrb});
    end
  end

  assign bus.arready = rst_n && idle;
  assign bus.awready = rst_n && idle;
  assign bus.wready  = rst_n && idle;
  assign bus.rvalid  = state == RD_RESP;
  assign bus.bvalid  = state == WR_RESP;
  assign bus.rdata   = rdata_q;
  assign bus.rresp   = OKAY;
  assign bus.bresp   = OKAY;

endmodule

// File: tb/tb_axil_dmem.sv
// Randomised bench for axil_dmem against a word-memory and delay model.
module tb_axil_dmem;
  import axil_pkg::*;

  logic clk = 1'b0;
  logic rst_n;

  axil_dmem_if bus();

  axil_dmem #(
    .MIN_LAT   (2),
    .RAND_MASK (4'h3),
    .LFSR_SEED (8'hA5)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int lfsr_m;
  logic [31:0] ref_mem [int unsigned];

  // Delay = MIN_LAT + (lfsr mod 4); the sequence steps once per accept.
  function automatic int next_delay();
    int d;
    d = 2 + lfsr_m % 4;
    lfsr_m = ((lfsr_m * 2) % 256)
           | ($countones(lfsr_m & 'hB8) % 2);
    return d;
  endfunction

  function automatic logic [31:0] mread(input logic [31:0] a);
    int unsigned k;
    k = a / 4;
    return ref_mem.exists(k) ? ref_mem[k] : 32'h0;
  endfunction

  function automatic void mwrite(input logic [31:0] a,
                                 input logic [31:0] d,
                                 input logic [3:0]  s);
    logic [31:0] w;
    w = mread(a);
    for (int i = 0; i < 4; i++)
      if (s[i]) w[8*i +: 8] = d[8*i +: 8];
    ref_mem[a / 4] = w;
  endfunction

  task automatic idle_bus();
    bus.araddr  = '0; bus.arvalid = 1'b0; bus.rready = 1'b0;
    bus.awaddr  = '0; bus.awvalid = 1'b0;
    bus.wdata   = '0; bus.wstrb   = '0;   bus.wvalid = 1'b0;
    bus.bready  = 1'b0;
  endtask

  task automatic axi_read(input  logic [31:0] a,
                          output int          lat,
                          output logic [31:0] d,
                          output bit          ok);
    bus.araddr = a; bus.arvalid = 1'b1; bus.rready = 1'b1;
    @(posedge clk); #1;
    bus.arvalid = 1'b0;
    lat = 0; ok = 1'b0;
    for (int i = 0; i < 40; i++)
      if (!ok) begin
        @(negedge clk); lat++; ok = bus.rvalid;
      end
    d = bus.rdata;
    @(posedge clk); #1;
    bus.rready = 1'b0;
  endtask

  task automatic axi_write(input  logic [31:0] a,
                           input  logic [31:0] d,
                           input  logic [3:0]  s,
                           output int          lat,
                           output bit          ok);
    bus.awaddr = a; bus.awvalid = 1'b1;
    bus.wdata  = d; bus.wstrb   = s; bus.wvalid = 1'b1;
    bus.bready = 1'b1;
    @(posedge clk); #1;
    bus.awvalid = 1'b0; bus.wvalid = 1'b0;
    lat = 0; ok = 1'b0;
    for (int i = 0; i < 40; i++)
      if (!ok) begin
        @(negedge clk); lat++; ok = bus.bvalid;
      end
    @(posedge clk); #1;
    bus.bready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle_bus();
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if ({bus.arready, bus.awready, bus.wready, bus.rvalid, bus.bvalid}
        !== 5'b0) begin
      n_bad++;
      $display("FAIL reset_hs: got %b want 00000",
        {bus.arready, bus.awready, bus.wready, bus.rvalid, bus.bvalid});
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    lfsr_m = 'hA5;
    @(negedge clk);
    n_cmp++;
    if ({bus.arready, bus.awready, bus.wready} !== 3'b111) begin
      n_bad++;
      $display("FAIL reset_ready: got %b want 111",
        {bus.arready, bus.awready, bus.wready});
    end
    n_cmp++;
    if ({bus.rdata, bus.rresp, bus.bresp} !== 36'h0) begin
      n_bad++;
      $display("FAIL reset_out: got %h want 0",
        {bus.rdata, bus.rresp, bus.bresp});
    end
    n_cmp++;
    if (dut.lfsr !== 8'hA5) begin
      n_bad++;
      $display("FAIL reset_lfsr: got %h want a5", dut.lfsr);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_fixed_latency();
    int lat, d;
    bit ok;
    logic [31:0] rd;
    d = next_delay();
    axi_write(32'h8000_0004, 32'hDEAD_BEEF, 4'hF, lat, ok);
    mwrite(32'h8000_0004, 32'hDEAD_BEEF, 4'hF);
    n_cmp++;
    if (!ok || lat != d + 1) begin
      n_bad++;
      $display("FAIL fix_wlat: got %0d want %0d", lat, d + 1);
    end
    n_cmp++;
    if (bus.bresp !== 2'b00) begin
      n_bad++;
      $display("FAIL fix_bresp: got %b want 00", bus.bresp);
    end
    d = next_delay();
    axi_read(32'h8000_0004, lat, rd, ok);
    n_cmp++;
    if (!ok || lat != d + 1) begin
      n_bad++;
      $display("FAIL fix_rlat: got %0d want %0d", lat, d + 1);
    end
    n_cmp++;
    if (rd !== 32'hDEAD_BEEF) begin
      n_bad++;
      $display("FAIL fix_rdata: got %h want deadbeef", rd);
    end
    n_cmp++;
    if (bus.rresp !== 2'b00) begin
      n_bad++;
      $display("FAIL fix_rresp: got %b want 00", bus.rresp);
    end
  endtask

  task automatic test_partial_write();
    int lat, d;
    int unsigned wc;
    bit ok;
    logic [31:0] rd;
    d = next_delay();
    axi_write(32'h8000_0010, 32'h1122_3344, 4'hF, lat, ok);
    mwrite(32'h8000_0010, 32'h1122_3344, 4'hF);
    wc = pmem_wr_cnt;
    d = next_delay();
    axi_write(32'h8000_0010, 32'h0000_AB00, 4'b0010, lat, ok);
    mwrite(32'h8000_0010, 32'h0000_AB00, 4'b0010);
    n_cmp++;
    if (!ok || lat != d + 1) begin
      n_bad++;
      $display("FAIL part_lat: got %0d want %0d", lat, d + 1);
    end
    n_cmp++;
    if (pmem_wr_cnt != wc + 1 || pmem_wr_mask !== 8'h02
        || pmem_wr_addr !== 32'h8000_0010) begin
      n_bad++;
      $display("FAIL part_dpi: got n=%0d m=%h a=%h want n=%0d m=02 a=80000010",
        pmem_wr_cnt - wc, pmem_wr_mask, pmem_wr_addr, 1);
    end
    d = next_delay();
    axi_read(32'h8000_0010, lat, rd, ok);
    n_cmp++;
    if (rd !== 32'h1122_AB44) begin
      n_bad++;
      $display("FAIL part_rdata: got %h want 1122ab44", rd);
    end
  endtask

  task automatic test_random();
    int lat, d;
    int unsigned wc;
    bit ok;
    logic [31:0] a, wd, rd, exp;
    logic [3:0] s;
    for (int i = 0; i < 24; i++) begin
      a = 32'h8000_0100 + ($urandom_range(0, 7) * 4)
        + $urandom_range(0, 3);
      d = next_delay();
      if ($urandom_range(0, 1) == 1) begin
        wd = $urandom;
        s  = 4'($urandom_range(0, 15));
        wc = pmem_wr_cnt;
        axi_write(a, wd, s, lat, ok);
        mwrite(a, wd, s);
        n_cmp++;
        if (!ok || lat != d + 1 || pmem_wr_cnt != wc + 1) begin
          n_bad++;
          $display("FAIL rnd_wr%0d: got lat=%0d n=%0d want lat=%0d n=1",
            i, lat, pmem_wr_cnt - wc, d + 1);
        end
      end else begin
        exp = mread(a);
        axi_read(a, lat, rd, ok);
        n_cmp++;
        if (!ok || lat != d + 1 || rd !== exp) begin
          n_bad++;
          $display("FAIL rnd_rd%0d: got lat=%0d d=%h want lat=%0d d=%h",
            i, lat, rd, d + 1, exp);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    int lat, d;
    bit ok;
    logic [31:0] exp;
    exp = mread(32'h8000_0004);
    d = next_delay();
    bus.araddr = 32'h8000_0004; bus.arvalid = 1'b1; bus.rready = 1'b0;
    @(posedge clk); #1;
    bus.arvalid = 1'b0;
    lat = 0; ok = 1'b0;
    for (int i = 0; i < 40; i++)
      if (!ok) begin
        @(negedge clk); lat++; ok = bus.rvalid;
      end
    n_cmp++;
    if (!ok || lat != d + 1) begin
      n_bad++;
      $display("FAIL bp_lat: got %0d want %0d", lat, d + 1);
    end
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      n_cmp++;
      if ({bus.rvalid, bus.arready} !== 2'b10 || bus.rdata !== exp) begin
        n_bad++;
        $display("FAIL bp_hold%0d: got v/rdy=%b d=%h want 10 d=%h",
          i, {bus.rvalid, bus.arready}, bus.rdata, exp);
      end
    end
    @(posedge clk); #1;
    bus.rready = 1'b1;
    @(posedge clk); #1;
    bus.rready = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({bus.rvalid, bus.arready} !== 2'b01) begin
      n_bad++;
      $display("FAIL bp_idle: got %b want 01",
        {bus.rvalid, bus.arready});
    end
    @(posedge clk); #1;
  endtask

  task automatic test_collision();
    int lat, dr, dw;
    int unsigned wc;
    bit ok;
    logic [31:0] exp;
    exp = mread(32'h8000_0010);
    wc  = pmem_wr_cnt;
    dr  = next_delay();
    bus.araddr = 32'h8000_0010; bus.arvalid = 1'b1; bus.rready = 1'b1;
    bus.awaddr = 32'h8000_0010; bus.awvalid = 1'b1;
    bus.wdata  = 32'h5A5A_5A5A; bus.wstrb   = 4'hF;
    bus.wvalid = 1'b1;          bus.bready  = 1'b1;
    @(posedge clk); #1;
    bus.arvalid = 1'b0;
    lat = 0; ok = 1'b0;
    for (int i = 0; i < 40; i++)
      if (!ok) begin
        @(negedge clk); lat++; ok = bus.rvalid;
      end
    n_cmp++;
    if (!ok || lat != dr + 1 || bus.rdata !== exp) begin
      n_bad++;
      $display("FAIL col_rd: got lat=%0d d=%h want lat=%0d d=%h",
        lat, bus.rdata, dr + 1, exp);
    end
    n_cmp++;
    if (pmem_wr_cnt != wc) begin
      n_bad++;
      $display("FAIL col_nowr: got %0d want 0", pmem_wr_cnt - wc);
    end
    dw = next_delay();
    lat = 0; ok = 1'b0;
    for (int i = 0; i < 40; i++)
      if (!ok) begin
        @(negedge clk); lat++; ok = bus.bvalid;
      end
    n_cmp++;
    if (!ok || lat != dw + 2) begin
      n_bad++;
      $display("FAIL col_wr: got %0d want %0d", lat, dw + 2);
    end
    @(posedge clk); #1;
    idle_bus();
    mwrite(32'h8000_0010, 32'h5A5A_5A5A, 4'hF);
    n_cmp++;
    if (pmem_wr_cnt != wc + 1) begin
      n_bad++;
      $display("FAIL col_wrcnt: got %0d want 1", pmem_wr_cnt - wc);
    end
  endtask

  task automatic test_split();
    int lat, d;
    int unsigned wc;
    bit ok;
    logic [31:0] rd;
    wc = pmem_wr_cnt;
    bus.awaddr = 32'h8000_0020; bus.awvalid = 1'b1; bus.bready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_cmp++;
      if ({bus.awready, bus.wready, bus.bvalid} !== 3'b110) begin
        n_bad++;
        $display("FAIL split%0d: got %b want 110",
          i, {bus.awready, bus.wready, bus.bvalid});
      end
      @(posedge clk); #1;
    end
    d = next_delay();
    bus.wdata = 32'hC0FF_EE11; bus.wstrb = 4'hF; bus.wvalid = 1'b1;
    @(posedge clk); #1;
    bus.awvalid = 1'b0; bus.wvalid = 1'b0;
    lat = 0; ok = 1'b0;
    for (int i = 0; i < 40; i++)
      if (!ok) begin
        @(negedge clk); lat++; ok = bus.bvalid;
      end
    n_cmp++;
    if (!ok || lat != d + 1 || pmem_wr_cnt != wc + 1) begin
      n_bad++;
      $display("FAIL split_acc: got lat=%0d n=%0d want lat=%0d n=1",
        lat, pmem_wr_cnt - wc, d + 1);
    end
    @(posedge clk); #1;
    bus.bready = 1'b0;
    mwrite(32'h8000_0020, 32'hC0FF_EE11, 4'hF);
    d = next_delay();
    axi_read(32'h8000_0020, lat, rd, ok);
    n_cmp++;
    if (rd !== 32'hC0FF_EE11) begin
      n_bad++;
      $display("FAIL split_rd: got %h want c0ffee11", rd);
    end
  endtask

  task automatic test_reset_wait();
    int lat;
    int unsigned wc;
    bit ok, seen;
    logic [31:0] rd, exp;
    exp = mread(32'h8000_0004);
    wc  = pmem_wr_cnt;
    bus.awaddr = 32'h8000_0004; bus.awvalid = 1'b1;
    bus.wdata  = 32'h0BAD_F00D; bus.wstrb   = 4'hF;
    bus.wvalid = 1'b1;          bus.bready  = 1'b1;
    @(posedge clk); #1;
    bus.awvalid = 1'b0; bus.wvalid = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({bus.arready, bus.awready, bus.wready, bus.bvalid} !== 4'b0) begin
      n_bad++;
      $display("FAIL rstw_hs: got %b want 0000",
        {bus.arready, bus.awready, bus.wready, bus.bvalid});
    end
    @(posedge clk); #1;
    rst_n  = 1'b1;
    lfsr_m = 'hA5;
    @(negedge clk);
    n_cmp++;
    if (dut.lfsr !== 8'hA5 || bus.rdata !== 32'h0
        || bus.arready !== 1'b1) begin
      n_bad++;
      $display("FAIL rstw_out: got l=%h d=%h r=%b want a5 0 1",
        dut.lfsr, bus.rdata, bus.arready);
    end
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      seen = seen | bus.bvalid;
    end
    n_cmp++;
    if (seen || pmem_wr_cnt != wc) begin
      n_bad++;
      $display("FAIL rstw_nowr: got b=%b n=%0d want 0 0",
        seen, pmem_wr_cnt - wc);
    end
    @(posedge clk); #1;
    bus.bready = 1'b0;
    void'(next_delay());
    axi_read(32'h8000_0004, lat, rd, ok);
    n_cmp++;
    if (!ok || rd !== exp) begin
      n_bad++;
      $display("FAIL rstw_mem: got %h want %h", rd, exp);
    end
  endtask

  initial begin
    test_reset();
    test_fixed_latency();
    test_partial_write();
    test_random();
    test_backpressure();
    test_collision();
    test_split();
    test_reset_wait();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
      n_cmp, n_bad);
    $finish;
  end

endmodule
